// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time, waits LAT settle cycles, then returns the result and NZVC flags.
// Illegal ops (divide/modulo by zero, op code > 9) return an error response one cycle after accept.
module alu_issue_ctrl #(
  parameter int WIDTH = 12,
  parameter int LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_n,
  input  logic               alu_z,
  input  logic               alu_v,
  input  logic               alu_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err,
  output logic [3:0]         flags_q
);

  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [3:0]           alu_sel_q, alu_sel_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic [3:0]           rsp_flags_q, rsp_flags_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [3:0]           last_flags_q, last_flags_d;
  logic                 op_illegal;

  assign req_ready = (state_q == IDLE) && !rst;

  // Divide/modulo by zero and unassigned op codes never reach the ALU wait.
  assign op_illegal = (((req_op == 4'b0011) || (req_op == 4'b0100)) && (req_b == '0))
                    || (req_op > 4'b1001);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    last_flags_d = last_flags_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_sel_d = req_op;
          cnt_d     = CW'(LAT - 1);
          if (op_illegal) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_flags_d  = 4'b0000;
            rsp_err_d    = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_out;
          rsp_flags_d  = {alu_n, alu_z, alu_v, alu_c};
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (!rsp_err_q) begin
            last_flags_d = rsp_flags_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= 4'b0000;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
      rsp_err_q    <= 1'b0;
      last_flags_q <= 4'b0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      last_flags_q <= last_flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign flags_q    = last_flags_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts one operation request at a time over a valid/ready handshake and drives operands and select to the ALU.
- Waits a fixed settle latency, then captures the ALU result and NZVC flags and returns them over a valid/ready response channel.
- Keeps a status register holding the flags of the last completed operation, for the execution stage and the branch logic.

Parameters:
- WIDTH, 12, operand width; the result is 2*WIDTH.
- LAT, 1, ALU settle cycles between operand launch and capture; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  4  ALU select code.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_sel  out  4  registered select to the ALU.
- alu_out  in  2*WIDTH  ALU result.
- alu_n, alu_z, alu_v, alu_c  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  2*WIDTH  captured result.
- rsp_flags  out  4  captured {N,Z,V,C}.
- rsp_err  out  1  rejected op (divide/modulo by zero, or op code > 4'b1001).
- flags_q  out  4  {N,Z,V,C} of the last successfully completed op.

Behaviour:
- Reset (synchronous, active-high), effective at the next edge:
  - state=IDLE, counter=0.
  - alu_a=0, alu_b=0, alu_sel=4'b0000.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, flags_q=0.
  - Reset overrides everything, including mid-WAIT and mid-RESP; any in-flight op is dropped with no response.
- req_ready=1 only in IDLE and only when rst=0. Combinational from state.
- States:
  - IDLE:
    - On req_valid&&req_ready: latch req_a/req_b/req_op into alu_a/alu_b/alu_sel and load counter=LAT-1.
    - If the op is legal, go to WAIT.
    - If req_op∈{0011,0100} with req_b=0, or req_op>4'b1001: go directly to RESP with rsp_result=0, rsp_flags=0, rsp_err=1. Operands are still latched.
  - WAIT:
    - Counter decrements each cycle.
    - At counter=0: capture rsp_result=alu_out, rsp_flags={alu_n,alu_z,alu_v,alu_c}, rsp_err=0, set rsp_valid=1, go to RESP.
    - Capture latency: the edge LAT cycles after the accept edge.
  - RESP:
    - rsp_valid=1; rsp_result, rsp_flags and rsp_err are stable while rsp_ready=0.
    - On rsp_valid&&rsp_ready: rsp_valid→0 and return to IDLE.
    - flags_q←rsp_flags at the same edge, only if rsp_err=0.
    - Error responses leave flags_q unchanged.
- Throughput: at most one op in flight; requests are never queued. Minimum accept-to-accept period is LAT+2 cycles with rsp_ready tied high.
- alu_a/alu_b/alu_sel hold their last issued values in IDLE and RESP, so no ALU input toggles outside an op.
- Requests offered in WAIT or RESP are ignored (req_ready=0). The requester must hold them; they are not latched.
- rsp_result is the full 2*WIDTH ALU output, with no sign extension or truncation. For non-multiply ops the upper WIDTH bits are passed as the ALU drives them.
- Counter width is $clog2(LAT)+1. No wrap: it is reloaded only on accept.

Test Plan (WIDTH=12, LAT=1, rsp_ready=1 unless stated):
- ADD: req_op=0000, A=100, B=200, accepted at edge k → rsp_valid=1 after edge k+1, rsp_result=300, rsp_flags=0000, rsp_err=0; flags_q=0000 after edge k+2; req_ready=1 after edge k+2.
- SUB: op=0001, A=5, B=5 → rsp_result=0, rsp_flags Z=1 (0100); flags_q=0100 after the handshake.
- MUL: op=0010, A=64, B=64 → rsp_result=24'h001000 (4096), rsp_err=0.
- DIV by zero: op=0011, A=7, B=0 → rsp_valid=1 one cycle after accept, rsp_err=1, rsp_result=0, flags_q unchanged from the prior value (0100 after the SUB test).
- Backpressure: ADD 1+1 with rsp_ready=0 for 3 cycles and req_valid held high with a second op → rsp_result=2 stable, req_ready=0 throughout; handshake on the cycle rsp_ready=1; second op accepted next cycle.
- Reset mid-op: op=0010 accepted, rst=1 during WAIT → after that edge rsp_valid=0, req_ready=1, alu_sel=0000, flags_q=0000, and no response is ever issued for the dropped op.
